// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch requester and a
// data (load/store) requester. Each transaction runs grant -> busy -> done.
// Every transaction is bounded by a busy-cycle timeout that returns zero data
// and pulses err.
//
// Configuration macro:
//   ARB_RR_EN  undefined : fixed priority, a data request always wins.
//              defined   : simultaneous requests alternate using a one-bit
//                          last-grant flag. The flag resets to "fetch", so data
//                          wins first.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   if_req/if_addr    fetch request and address, held until if_ack
//   if_rdata/if_ack   fetch data (holds between transactions); one-cycle done
//   d_rena/d_wena     load / store request (both high is a store)
//   d_addr/d_wdata    data address and store data, held until d_ack
//   d_rdata/d_ack     load data (holds between transactions); one-cycle done
//   mem_ce/mem_we     memory enable (high only while busy) / write enable
//   mem_addr/wdata    registered at grant, stable while busy
//   mem_rdata/ready   memory read data and completion strobe
//   stall             combinational pipeline hold
//   err               timeout pulse, coincident with the ack
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter  int unsigned TIMEOUT = 16,
   localparam int unsigned DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   // fetch port
   input  logic          if_req,
   input  logic [DW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   // data port
   input  logic          d_rena,
   input  logic          d_wena,
   input  logic [DW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   // memory side
   output logic          mem_ce,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   // status
   output logic          stall,
   output logic          err
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   busy_cnt;
   logic               d_req;
   logic               grant_d;
   logic               busy;
   logic               timeout_hit;
   logic [DW-1:0]      ret_data;

`ifdef ARB_RR_EN
   // 1: data was granted last, 0: fetch was granted last
   logic               last_gnt_d;
`endif

   // Request decode, arbitration choice and completion conditions
   always_comb begin
      d_req       = d_rena | d_wena;
      busy        = (state == IF_BUSY) || (state == D_BUSY);
      timeout_hit = busy && !mem_ready && (busy_cnt == CNT_W'(TIMEOUT - 1));
      // A timed-out access returns zero instead of whatever is on the bus
      ret_data    = mem_ready ? mem_rdata : '0;
`ifdef ARB_RR_EN
      // Contended grant goes to whoever was not served last; lone requests win
      grant_d     = d_req && (!if_req || !last_gnt_d);
`else
      grant_d     = d_req;
`endif
   end

   // Pipeline hold while a requester waits for its ack
   assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

   // Arbiter FSM with registered memory-side and requester-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy_cnt   <= '0;
         mem_ce     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         err        <= 1'b0;
`ifdef ARB_RR_EN
         last_gnt_d <= 1'b0;
`endif
      end else begin
         // Acks and err are single-cycle pulses
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         err    <= 1'b0;

         case (state)
            IDLE: begin
               if ((if_req || d_req) && !if_ack && !d_ack) begin
                  mem_ce   <= 1'b1;
                  busy_cnt <= '0;
                  if (grant_d) begin
                     state      <= D_BUSY;
                     mem_addr   <= d_addr;
                     // Load+store together resolves to a store
                     mem_we     <= d_wena;
                     mem_wdata  <= d_wdata;
`ifdef ARB_RR_EN
                     last_gnt_d <= 1'b1;
`endif
                  end else begin
                     state      <= IF_BUSY;
                     mem_addr   <= if_addr;
                     mem_we     <= 1'b0;
                     mem_wdata  <= '0;
`ifdef ARB_RR_EN
                     last_gnt_d <= 1'b0;
`endif
                  end
               end
            end

            IF_BUSY, D_BUSY: begin
               if (mem_ready || timeout_hit) begin
                  state  <= DONE;
                  mem_ce <= 1'b0;
                  mem_we <= 1'b0;
                  err    <= timeout_hit;
                  if (state == IF_BUSY) begin
                     if_ack   <= 1'b1;
                     if_rdata <= ret_data;
                  end else begin
                     d_ack <= 1'b1;
                     // Stores leave the load-data register untouched
                     if (!mem_we) begin
                        d_rdata <= ret_data;
                     end
                  end
               end else begin
                  busy_cnt <= busy_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Expected transactions are queued as they
// are requested and checked when an ack appears. A small memory responder
// answers with an address-derived word after a programmable busy latency.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_rena;
   logic        d_wena;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        mem_ce;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        stall;
   logic        err;

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_rena    (d_rena),
      .d_wena    (d_wena),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .mem_ce    (mem_ce),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall     (stall),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          err;
      int          ce;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_if_rdata = 32'h0;
   logic [31:0] m_d_rdata  = 32'h0;

   // Responder controls: ready_lat = busy cycle that sees ready (0 = never)
   int          ready_lat  = 1;
   bit          ready_idle = 1'b0;
   int          busy_n     = 0;

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0050_0093;
      return a ^ 32'h5A5A_F00F;
   endfunction

   // Memory responder, updated away from the active edge
   always @(negedge clk) begin
      if (mem_ce) begin
         busy_n    = busy_n + 1;
         mem_ready = (ready_lat != 0) && (busy_n == ready_lat);
         mem_rdata = rd_of(mem_addr);
      end else begin
         busy_n    = 0;
         mem_ready = ready_idle;
         mem_rdata = 32'hBAD0_BAD0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic push(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit e_err, input int ce, input int lat);
      exp_t e;
      e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
      e.err = e_err; e.ce = ce; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Wait for the next ack, check it against the queue head.
   // drop_mode: 0 keep requests, 1 drop the acked requester, 2 drop all.
   task automatic wait_ack(input string tag, input int budget, input int drop_mode);
      int          ce_n;
      int          lat;
      bit          seen;
      bit          got_d;
      logic        we_s;
      logic [31:0] addr_s;
      logic [31:0] wd_s;
      exp_t        e;
      ce_n = 0; lat = 0; seen = 1'b0; we_s = 1'b0; addr_s = '0; wd_s = '0;
      while (!seen && lat < budget) begin
         @(negedge clk);
         lat++;
         if (mem_ce) begin
            ce_n++;
            we_s   = mem_we;
            addr_s = mem_addr;
            wd_s   = mem_wdata;
         end
         if (if_ack || d_ack) seen = 1'b1;
      end
      chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
      if (!seen) return;
      chk({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() == 0) return;
      e     = exp_q.pop_front();
      got_d = d_ack;
      if (!e.we) begin
         if (e.is_d) m_d_rdata  = e.err ? 32'h0 : rd_of(e.addr);
         else        m_if_rdata = e.err ? 32'h0 : rd_of(e.addr);
      end
      chk({tag, "_chan_d"},   32'(got_d), 32'(e.is_d));
      chk({tag, "_ack_both"}, 32'(if_ack & d_ack), 32'd0);
      chk({tag, "_err"},      32'(err), 32'(e.err));
      chk({tag, "_ce_cyc"},   32'(ce_n), 32'(e.ce));
      chk({tag, "_addr"},     addr_s, e.addr);
      chk({tag, "_we"},       32'(we_s), 32'(e.we));
      if (e.we) chk({tag, "_wdata"}, wd_s, e.wdata);
      chk({tag, "_if_rdata"}, if_rdata, m_if_rdata);
      chk({tag, "_d_rdata"},  d_rdata, m_d_rdata);
      chk({tag, "_lat"},      32'(lat), 32'(e.lat));
      if (drop_mode == 2 || (drop_mode == 1 && got_d)) begin
         d_rena = 1'b0; d_wena = 1'b0;
      end
      if (drop_mode == 2 || (drop_mode == 1 && !got_d)) begin
         if_req = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_pulse_end"}, {29'h0, if_ack, d_ack, err}, 32'h0);
      chk({tag, "_ce_after"},  32'(mem_ce), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_ce"},    32'(mem_ce), 32'd0);
      chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
      chk({tag, "_acks_err"},  {29'h0, if_ack, d_ack, err}, 32'h0);
      chk({tag, "_mem_addr"},  mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_if_rdata"},  if_rdata, 32'h0);
      chk({tag, "_d_rdata"},   d_rdata, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      d_rena = 1'b0; d_wena = 1'b0; d_addr = '0; d_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      chk("rst0_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Fetch, ready on the second busy cycle
      ready_lat = 2;
      push(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 2, 3);
      if_req = 1'b1; if_addr = 32'h100;
      #1 chk("fetch_stall_req", 32'(stall), 32'd1);
      wait_ack("fetch", 10, 1);
      chk("fetch_rdata_lit", if_rdata, 32'h0050_0093);
      chk("fetch_stall_after", 32'(stall), 32'd0);

      // Store with immediate ready
      ready_lat = 1;
      push(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b0, 1, 2);
      d_wena = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
      wait_ack("store", 10, 1);

      // Load
      push(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1, 2);
      d_rena = 1'b1; d_addr = 32'h3000; d_wdata = 32'h0;
      wait_ack("load", 10, 1);

      // Load+store together is a store; d_rdata keeps the load value
      push(1'b1, 1'b1, 32'h3004, 32'h1234_5678, 1'b0, 1, 2);
      d_rena = 1'b1; d_wena = 1'b1; d_addr = 32'h3004; d_wdata = 32'h1234_5678;
      wait_ack("ldst", 10, 1);

      // mem_ready while idle must be ignored
      ready_idle = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ready_ce", 32'(mem_ce), 32'd0);
         chk("idle_ready_ack", {30'h0, if_ack, d_ack}, 32'h0);
      end
      ready_idle = 1'b0;
      @(negedge clk);

      // Contention from reset: data first, then fetch
      rst = 1'b1;
      @(negedge clk);
      m_if_rdata = 32'h0; m_d_rdata = 32'h0;
      if_req = 1'b1; if_addr = 32'h400;
      d_rena = 1'b1; d_addr = 32'h500;
      rst = 1'b0;
      push(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1, 2);
      push(1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 1, 2);
      wait_ack("cont_d", 10, 1);
      wait_ack("cont_if", 10, 1);

      // Sustained dual requests
      if_req = 1'b1; if_addr = 32'h800;
      d_rena = 1'b1; d_addr = 32'h900;
`ifdef ARB_RR_EN
      push(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1, 2);
      push(1'b0, 1'b0, 32'h800, 32'h0, 1'b0, 1, 2);
      push(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1, 2);
      push(1'b0, 1'b0, 32'h800, 32'h0, 1'b0, 1, 2);
`else
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1, 2);
`endif
      wait_ack("dual0", 10, 0);
      wait_ack("dual1", 10, 0);
      wait_ack("dual2", 10, 0);
      wait_ack("dual3", 10, 2);

      // Timeout: ready never comes
      ready_lat = 0;
      push(1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 16, 17);
      d_rena = 1'b1; d_addr = 32'h600;
      wait_ack("tmo", 40, 1);
      chk("tmo_d_rdata_zero", d_rdata, 32'h0);

      // Reset during D_BUSY, then re-grant of the held load
      d_rena = 1'b1; d_addr = 32'h700;
      repeat (3) @(negedge clk);
      chk("midrst_busy", 32'(mem_ce), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      m_if_rdata = 32'h0; m_d_rdata = 32'h0;
      check_reset_outputs("midrst");
      rst = 1'b0;
      ready_lat = 1;
      push(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 1, 2);
      wait_ack("regrant", 10, 1);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports if_req in 1 (fetch request), if_addr in 32 (fetch address), if_rdata out 32 (fetch data), if_ack out 1 (fetch done).
REQ-004 SHALL have ports d_rena in 1 (load request, from mem_rena), d_wena in 1 (store request, from mem_wena), d_addr in 32, d_wdata in 32, d_rdata out 32, d_ack out 1.
REQ-005 SHALL have ports mem_ce out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ready in 1 (single-port memory side).
REQ-006 SHALL have ports stall out 1 (pipeline hold) and err out 1 (timeout pulse).
REQ-007 SHALL have parameter TIMEOUT, default 16, meaning the maximum busy cycles before abort.

Function
REQ-008 SHALL implement states IDLE, IF_BUSY, D_BUSY, DONE.
REQ-009 IDLE: if any request is pending and no ack is high, SHALL grant one requester and enter IF_BUSY or D_BUSY on the next edge.
REQ-010 On grant, SHALL register mem_addr, mem_we, and mem_wdata from the granted requester, and hold them constant while busy.
REQ-011 SHALL drive mem_ce high exactly while in IF_BUSY or D_BUSY.
REQ-012 d_rena and d_wena both high SHALL be treated as a store (mem_we=1); d_rdata SHALL be left unchanged.
REQ-013 Busy state with mem_ready=1: SHALL capture mem_rdata into the granted rdata register (loads/fetch only) and enter DONE.
REQ-014 DONE: SHALL assert the granted ack for exactly one cycle, then return to IDLE; minimum transaction length SHALL be 3 cycles (grant, ready, ack).
REQ-015 Requesters SHALL hold request and address until ack; a request dropped before ack SHALL still complete, with the ack ignored.
REQ-016 A busy-cycle counter SHALL clear on grant and increment each busy cycle without mem_ready.
REQ-017 When the count reaches TIMEOUT-1 with no mem_ready: SHALL enter DONE, pulse err together with the ack, and force the returned rdata to 0.
REQ-018 stall SHALL be combinational: (if_req & ~if_ack) | ((d_rena | d_wena) & ~d_ack).
REQ-019 mem_ready in IDLE or DONE SHALL be ignored.
REQ-020 if_rdata and d_rdata SHALL hold their last values between transactions.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, with mem_ce, mem_we, if_ack, d_ack, and err at 0.
REQ-022 Reset SHALL also clear mem_addr, mem_wdata, if_rdata, d_rdata, the timeout counter, and the last-grant flag to 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction with no ack; requests still high after reset release SHALL be re-arbitrated from IDLE.

Configuration
REQ-024 With ARB_RR_EN undefined, IDLE SHALL use fixed priority: a data request always wins over if_req.
REQ-025 With ARB_RR_EN defined, simultaneous requests SHALL go to the requester not granted last (tracked by a one-bit last-grant flag, reset to fetch), so data wins first after reset.
REQ-026 With ARB_RR_EN defined, a single pending request SHALL be granted regardless of the last-grant flag.

Verification
REQ-027 Fetch only: if_req=1, if_addr=0x100, mem_ready on the 2nd busy cycle, mem_rdata=0x00500093 -> mem_ce high for 2 cycles, if_rdata=0x00500093, one-cycle if_ack, stall low the cycle after ack.
REQ-028 Store: d_wena=1, d_addr=0x2000, d_wdata=0xDEADBEEF, immediate mem_ready -> mem_we=1, mem_wdata=0xDEADBEEF, d_ack 2 cycles after request, d_rdata unchanged.
REQ-029 Contention: if_req and d_rena high together from reset, both held -> data served first; then fetch in both configurations; with ARB_RR_EN, sustained dual requests alternate D, IF, D, IF.
REQ-030 Timeout: d_rena=1, mem_ready never asserted -> mem_ce high for 16 cycles, then err=1 with d_ack=1 for one cycle, d_rdata=0.
REQ-031 Reset mid-op: rst pulsed during D_BUSY -> next cycle mem_ce=0, no d_ack, all outputs 0; held d_rena is re-granted after release.
REQ-032 Load+store conflict: d_rena=d_wena=1, d_wdata=0x12345678 -> a write is issued, d_rdata keeps its prior value.
